// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared state, opcode and mux-select encodings for the
//                multicycle main control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    LONGEXEC = 4'd10,
    LONGWB   = 4'd11,
    UNKNOWN  = 4'd12
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_FPU = 2'b11;

  localparam logic [3:0] MUL_PATTERN = 4'b1001;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_UNIT      = 2'b11;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  function automatic logic is_mul(input logic [1:0] op, input logic [5:0] funct,
                                  input logic [3:0] mul);
    return (op == OP_DP) && (funct[5:4] == 2'b00) && (mul == MUL_PATTERN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/long_op_timer.sv
// ============================================================================
//  Module      : long_op_timer
//  Description : Saturating cycle counter with expire compare for the
//                long-op watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module long_op_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TMR_W-1:0] c_max = '1;

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_max)) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam logic [TMR_W-1:0] c_limit = TMR_W'(TIMEOUT_CYCLES - 1);
      assign o_expire = (r_count == c_limit);
    end else begin : g_no_wdog
      assign o_expire = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mc_mainfsm_ext.sv
// ============================================================================
//  Module      : mc_mainfsm_ext
//  Description : Multicycle main control FSM with MUL/FPU long-op handshake,
//                condition pre-check and watchdog abort.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_mainfsm_ext
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = 8,
  parameter int FPU_EN         = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Mul,
  input  logic       CondEx,
  input  logic       UnitDone,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       FPUW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       UnitStart,
  output logic       UnitSel,
  output logic       Fault
);

  state_t r_state;
  state_t w_next;
  logic   r_unit_start;
  logic   r_unit_sel;
  logic   r_fault;
  logic   w_is_fpu;
  logic   w_is_long;
  logic   w_long_go;
  logic   w_expire;
  logic   w_abort;
  logic   w_unused;

  assign w_is_fpu  = (FPU_EN != 0) && (Op == OP_FPU);
  assign w_is_long = is_mul(Op, Funct, Mul) || w_is_fpu;
  assign w_long_go = (r_state == DECODE) && (w_next == LONGEXEC);
  // UnitDone has priority over the watchdog on the same cycle
  assign w_abort   = (r_state == LONGEXEC) && !UnitDone && w_expire;
  assign w_unused  = &{1'b0, Funct[3:1]};

  long_op_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_long_go),
    .i_en     (r_state == LONGEXEC),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = DECODE;
      DECODE: begin
        if (Op == OP_MEM)        w_next = MEMADR;
        else if (Op == OP_BR)    w_next = BRANCH;
        else if (w_is_long)      w_next = CondEx ? LONGEXEC : FETCH;
        else if (Op == OP_DP)    w_next = Funct[5] ? EXECUTEI : EXECUTER;
        else                     w_next = UNKNOWN;
      end
      MEMADR:   w_next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      LONGEXEC: begin
        if (UnitDone)      w_next = LONGWB;
        else if (w_expire) w_next = FETCH;
        else               w_next = LONGEXEC;
      end
      default:  w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_unit_start <= 1'b0;
      r_unit_sel   <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_unit_start <= w_long_go;
      if (w_long_go) r_unit_sel <= w_is_fpu;
      if (w_abort)   r_fault    <= 1'b1;
    end
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    FPUW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_RN;
    ALUSrcB   = SRCB_RM;
    ResultSrc = RES_ALUOUT;
    case (r_state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR:   ALUSrcB = SRCB_EXTIMM;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = SRCB_EXTIMM;
        ALUOp   = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      LONGWB: begin
        ResultSrc = RES_UNIT;
        RegW      = !r_unit_sel;
        FPUW      = r_unit_sel;
      end
      default: ;
    endcase
  end

  assign UnitStart = r_unit_start;
  assign UnitSel   = r_unit_sel;
  assign Fault     = r_fault;

endmodule

`default_nettype wire

// File: doc/mc_mainfsm_ext.md
Name: mc_mainfsm_ext

Overview:
- Next-generation multicycle main control FSM for the ARM-subset core; it sits inside `decode`, feeding condlogic and the datapath muxes.
- Extends the classic fetch/decode/execute sequence with a long-latency execution path: MUL and FPU ops run through a start/done handshake to an external unit.
- Adds an optional watchdog timeout that aborts a hung long op.
- Adds condition pre-check so a failed-condition long op never starts its unit.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent in LONGEXEC before abort; 0 disables the watchdog.
- TMR_W, 8, width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.
- FPU_EN, 1, when 0 the Op=11 encoding decodes as UNKNOWN instead of an FPU op.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Mul  in  4  Instr[7:4]
- CondEx  in  1  condition-passed flag from condlogic, valid in DECODE
- UnitDone  in  1  long unit result valid, one-cycle pulse
- IRWrite  out  1  instruction register load
- NextPC  out  1  PC update request
- RegW  out  1  register write request (gated by condlogic)
- MemW  out  1  memory write request (gated by condlogic)
- FPUW  out  1  FPU register write request
- Branch  out  1  branch request
- ALUOp  out  1  ALU decoder enable
- AdrSrc  out  1  0=PC, 1=ALUOut
- ALUSrcA  out  2  00=Rn, 01=PC, 10=ALUOut
- ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=UnitResult
- UnitStart  out  1  one-cycle long-unit launch
- UnitSel  out  1  0=MUL, 1=FPU; held stable from UnitStart until LONGWB exits
- Fault  out  1  sticky watchdog abort flag

Behaviour:
- Reset (reset=0, async): state=FETCH, timer=0, Fault=0, UnitSel=0. Registered outputs are 0.
- FETCH outputs are combinational from state (Moore), so they appear immediately after reset release.
- Default value for any output not listed in a state: 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state, in priority order:
  - Op=01 -> MEMADR.
  - Op=10 -> BRANCH.
  - Op=00 with Funct[5:4]=00 and Mul=1001 (MUL), or Op=11 with FPU_EN=1 (FPU) -> LONGEXEC if CondEx=1, else FETCH.
  - Op=00 with Funct[5]=0 -> EXECUTER.
  - Op=00 with Funct[5]=1 -> EXECUTEI.
  - Anything else -> UNKNOWN.
- MEMADR: ALUSrcA=00, ALUSrcB=01. Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1. Next state: FETCH.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Next state: ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next state: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1. Next state: FETCH.
- LONGEXEC entry (the DECODE->LONGEXEC transition):
  - UnitStart is registered high for exactly the first LONGEXEC cycle.
  - UnitSel is latched: 1 for FPU, 0 for MUL.
  - timer is cleared to 0.
- LONGEXEC cycles: timer increments each cycle, saturating at 2^TMR_W-1.
- LONGEXEC exits:
  - UnitDone=1 -> LONGWB. UnitDone is honoured on any LONGEXEC cycle, including the UnitStart cycle (zero-latency unit).
  - TIMEOUT_CYCLES>0 and timer==TIMEOUT_CYCLES-1 with UnitDone=0 -> FETCH, Fault set to 1. No register write occurs.
  - If UnitDone and the timeout coincide, UnitDone wins: go to LONGWB, Fault unchanged.
- LONGWB: ResultSrc=11; RegW=1 if UnitSel=0, FPUW=1 if UnitSel=1. Next state: FETCH.
- UnitDone outside LONGEXEC is ignored.
- UNKNOWN: all outputs 0. Next state: FETCH; the instruction is treated as a NOP.
- Fault is sticky and is cleared only by reset.
- Reset asserted mid-LONGEXEC: immediate return to FETCH, UnitStart=0, no write.

Decomposition:
- Shared package `ctrl_pkg` holds:
  - the 4-bit state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, LONGEXEC, LONGWB, UNKNOWN;
  - Op codes OP_DP=00, OP_MEM=01, OP_BR=10, OP_FPU=11;
  - the MUL_PATTERN=1001 constant;
  - the ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module, `long_op_timer`, holds the saturating counter, the clear/enable controls and the expire compare.

Test Plan:
- Reset and walk: reset low mid-run, then release; fetch of ADD reg (Op=00, Funct=000100) -> FETCH, DECODE, EXECUTER, ALUWB with RegW=1 in cycle 4, then back to FETCH.
- LDR then STR (Op=01, Funct[0]=1, then 0) -> LDR takes 5 cycles with ResultSrc=01 in MEMWB; STR takes 4 cycles with MemW=1 and AdrSrc=1 in cycle 4.
- MUL with CondEx=1, UnitDone pulsed 3 cycles after UnitStart -> UnitStart high for exactly 1 cycle, UnitSel=0, LONGWB with RegW=1 and ResultSrc=11; total 7 cycles.
- FPU op with CondEx=0 -> DECODE goes straight to FETCH, UnitStart never asserts. Repeat with FPU_EN=0 -> UNKNOWN, then FETCH.
- TIMEOUT_CYCLES=4, FPU op with UnitDone never asserted -> 4 LONGEXEC cycles, then FETCH with Fault=1 and no FPUW. Fault stays 1 through a following ADD until reset.
- Boundary: UnitDone coincident with timer==TIMEOUT_CYCLES-1 -> LONGWB, Fault stays 0. UnitDone on the UnitStart cycle -> LONGWB on the next cycle.
